// File: rtl/video_timing_monitor.sv
// Video timing monitor: measures line, frame and active-area geometry from hsync/vsync/de and locks after LOCK_FRAMES matching frames.
// Latency: frameStart 1 cycle after a vsync rise; mismatch/locked/errCnt update 2 cycles after it, in the cycle following frameStart.
// Backpressure: none. This is a passive monitor and never stalls its inputs.
//
// Optional feature: define VIDEO_TIMING_MONITOR_ERRCNT_EN to build the 16-bit saturating mismatched-frame counter.
// Without it, errCnt is tied to 0.
//
// Ports:
//   pxlClk, rstN           pixel clock; asynchronous active-low reset
//   hsync, vsync, de       active-high video timing inputs, synchronous to pxlClk
//   lineLen                clocks between the last two hsync rises (saturates at 2047)
//   frameLines, actH       lines and de-active lines counted over the last frame
//   actW                   de-high clocks on the last active line
//   locked                 level, high while the timing is locked
//   frameStart, mismatch   single-cycle pulses
//   errCnt                 count of mismatched frames
module video_timing_monitor #(
  parameter int WIDTH_TOTAL  = 1650,
  parameter int HEIGHT_TOTAL = 750,
  parameter int ACTIVE_W     = 1280,
  parameter int ACTIVE_H     = 720,
  parameter int LOCK_FRAMES  = 4
) (
  input  logic        pxlClk,
  input  logic        rstN,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  output logic [10:0] lineLen,
  output logic [9:0]  frameLines,
  output logic [10:0] actW,
  output logic [9:0]  actH,
  output logic        locked,
  output logic        frameStart,
  output logic        mismatch,
  output logic [15:0] errCnt
);

  localparam logic [10:0] PXL_MAX  = 11'd2047;
  localparam logic [9:0]  LINE_MAX = 10'd1023;
  localparam logic [10:0] W_TOT    = 11'(WIDTH_TOTAL);
  localparam logic [9:0]  H_TOT    = 10'(HEIGHT_TOTAL);
  localparam logic [10:0] A_W      = 11'(ACTIVE_W);
  localparam logic [9:0]  A_H      = 10'(ACTIVE_H);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state;
  logic [3:0]  good_cnt;
  logic        hs_q, vs_q, de_q;
  logic [10:0] pxl_cnt, de_cnt;
  logic [9:0]  line_cnt, act_line_cnt;
  logic        line_err, sat_err, skip_first;
  logic        err_cap, sat_cap, eval;

  logic hs_rise, vs_rise, de_rise, de_fall;
  logic hs_bad, any_sat, frame_ok, mis_now;

  assign hs_rise = hsync & ~hs_q;
  assign vs_rise = vsync & ~vs_q;
  assign de_rise = de & ~de_q;
  assign de_fall = ~de & de_q;

  // The first hsync rise after vsync closes a line that may have started
  // before the frame boundary, so its length is not held against the frame.
  assign hs_bad  = hs_rise & ~skip_first & (pxl_cnt != W_TOT);

  // A counter sitting at its ceiling means the measurement is meaningless.
  assign any_sat = (pxl_cnt == PXL_MAX) | (de_cnt == PXL_MAX) |
                   (line_cnt == LINE_MAX) | (act_line_cnt == LINE_MAX);

  // Evaluated the cycle after vsync rise, when the captured frame values
  // (including an actW written by a coincident de fall) have settled.
  assign frame_ok = (frameLines == H_TOT) && (actH == A_H) && (actW == A_W) &&
                    !err_cap && !sat_cap;
  assign mis_now  = eval && !frame_ok && (state != SEARCH);

  // Measurement datapath
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      pxl_cnt      <= '0;
      de_cnt       <= '0;
      line_cnt     <= '0;
      act_line_cnt <= '0;
      line_err     <= 1'b0;
      sat_err      <= 1'b0;
      skip_first   <= 1'b0;
      err_cap      <= 1'b0;
      sat_cap      <= 1'b0;
      lineLen      <= '0;
      frameLines   <= '0;
      actW         <= '0;
      actH         <= '0;
      frameStart   <= 1'b0;
    end else begin
      hs_q       <= hsync;
      vs_q       <= vsync;
      de_q       <= de;
      frameStart <= vs_rise;

      if (hs_rise) begin
        lineLen <= pxl_cnt;
        pxl_cnt <= 11'd1;
      end else if (pxl_cnt != PXL_MAX) begin
        pxl_cnt <= pxl_cnt + 11'd1;
      end

      if (de_fall) begin
        actW   <= de_cnt;
        de_cnt <= '0;
      end else if (de && (de_cnt != PXL_MAX)) begin
        de_cnt <= de_cnt + 11'd1;
      end

      if (vs_rise) begin
        // An hsync rise coincident with vsync still belongs to the old frame.
        frameLines   <= (hs_rise && (line_cnt != LINE_MAX)) ? line_cnt + 10'd1 : line_cnt;
        actH         <= act_line_cnt;
        line_cnt     <= '0;
        act_line_cnt <= '0;
        err_cap      <= line_err | hs_bad;
        sat_cap      <= sat_err | any_sat;
        line_err     <= 1'b0;
        sat_err      <= 1'b0;
        skip_first   <= 1'b1;
      end else begin
        if (hs_rise && (line_cnt != LINE_MAX))
          line_cnt <= line_cnt + 10'd1;
        if (de_rise && (act_line_cnt != LINE_MAX))
          act_line_cnt <= act_line_cnt + 10'd1;
        if (hs_bad)
          line_err <= 1'b1;
        if (any_sat)
          sat_err <= 1'b1;
        if (hs_rise)
          skip_first <= 1'b0;
      end
    end
  end

  // Lock state machine
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      state    <= SEARCH;
      good_cnt <= '0;
      eval     <= 1'b0;
      locked   <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      // The vsync rise that leaves SEARCH ends a partial frame: never classified.
      eval     <= vs_rise && (state != SEARCH);
      mismatch <= mis_now;
      case (state)
        SEARCH: begin
          if (vs_rise) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end
        end
        MEASURE: begin
          if (eval) begin
            if (frame_ok) begin
              good_cnt <= good_cnt + 4'd1;
              if ((good_cnt + 4'd1) == LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          if (eval && !frame_ok) begin
            state    <= MEASURE;
            good_cnt <= '0;
            locked   <= 1'b0;
          end
        end
        default: begin
          state    <= SEARCH;
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      endcase
    end
  end

`ifdef VIDEO_TIMING_MONITOR_ERRCNT_EN
  // Increments on the same edge that raises mismatch; cleared only by reset.
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN)
      errCnt <= '0;
    else if (mis_now && (errCnt != 16'hFFFF))
      errCnt <= errCnt + 16'd1;
  end
`else
  assign errCnt = '0;
`endif

endmodule

// File: tb/tb_video_timing_monitor.sv
// Randomized frame-level bench for video_timing_monitor using a scaled raster.
// Expected values come from a frame-description model: per-frame line lengths, line count and de lines.
// Lock and mismatch are predicted from a run-length of good frames.
module tb_video_timing_monitor;

  localparam int WT = 24;
  localparam int HT = 12;
  localparam int AW = 16;
  localparam int AH = 8;
  localparam int LF = 4;
  localparam int HS_W     = 2;
  localparam int DE_START = 4;
  localparam int VS_MID   = 8;
  localparam int VS_LINES = 3;

  logic        pxlClk = 1'b0;
  logic        rstN   = 1'b0;
  logic        hsync  = 1'b0;
  logic        vsync  = 1'b0;
  logic        de     = 1'b0;
  logic [10:0] lineLen;
  logic [9:0]  frameLines;
  logic [10:0] actW;
  logic [9:0]  actH;
  logic        locked, frameStart, mismatch;
  logic [15:0] errCnt;

  video_timing_monitor #(
    .WIDTH_TOTAL(WT), .HEIGHT_TOTAL(HT), .ACTIVE_W(AW), .ACTIVE_H(AH), .LOCK_FRAMES(LF)
  ) dut (
    .pxlClk(pxlClk), .rstN(rstN), .hsync(hsync), .vsync(vsync), .de(de),
    .lineLen(lineLen), .frameLines(frameLines), .actW(actW), .actH(actH),
    .locked(locked), .frameStart(frameStart), .mismatch(mismatch), .errCnt(errCnt)
  );

  always #5 pxlClk = ~pxlClk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit armed = 0;
  int streak = 0;
  int exp_mis = 0;
  int exp_err = 0;
  int vs_rises = 0;
  int prev_lines = 0, prev_act = 0, prev_last = 0;
  bit prev_bad = 0;

  // Pending expectations
  bit chk_fs = 0, chk_cls = 0, e_data = 0, e_mis = 0, e_lock = 0;
  int e_lines = 0, e_act = 0, e_len = 0, e_cnt = 0;

  int mon_fs = 0, mon_mis = 0;
  always @(negedge pxlClk) begin
    if (frameStart) mon_fs++;
    if (mismatch)   mon_mis++;
  end

  task automatic on_vs_rise();
    bit good;
    vs_rises++;
    if (!armed) begin
      armed  = 1;
      e_data = 0;
      e_mis  = 0;
      e_lock = 0;
    end else begin
      good = !prev_bad && (prev_lines == HT) && (prev_act == AH);
      if (good) begin
        streak++;
      end else begin
        streak = 0;
        exp_mis++;
        if (exp_err < 65535) exp_err++;
      end
      e_data  = 1;
      e_lines = prev_lines;
      e_act   = prev_act;
      e_len   = (prev_last > 2047) ? 2047 : prev_last;
      e_mis   = !good;
      e_lock  = (streak >= LF);
    end
`ifdef VIDEO_TIMING_MONITOR_ERRCNT_EN
    e_cnt = exp_err;
`else
    e_cnt = 0;
`endif
    chk_fs = 1;
  endtask

  task automatic tick();
    @(posedge pxlClk);
    #1;
    if (chk_cls) begin
      check("mismatch", mismatch, e_mis);
      check("locked", locked, e_lock);
      check("errCnt", errCnt, e_cnt);
      chk_cls = 0;
    end
    if (chk_fs) begin
      check("frameStart", frameStart, 1);
      if (e_data) begin
        check("frameLines", frameLines, e_lines);
        check("actH", actH, e_act);
        check("actW", actW, AW);
        check("lineLen", lineLen, e_len);
      end
      chk_fs  = 0;
      chk_cls = 1;
    end
  endtask

  task automatic drive(input logic h, input logic v, input logic d);
    logic rise;
    rise  = v & ~vsync;
    hsync = h;
    vsync = v;
    de    = d;
    if (rise) on_vs_rise();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lineLen"}, lineLen, 0);
    check({tag, "_frameLines"}, frameLines, 0);
    check({tag, "_actW"}, actW, 0);
    check({tag, "_actH"}, actH, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_frameStart"}, frameStart, 0);
    check({tag, "_mismatch"}, mismatch, 0);
    check({tag, "_errCnt"}, errCnt, 0);
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    #1;
    check_all_zero("rst_async");
    armed   = 0;
    streak  = 0;
    exp_err = 0;
    chk_fs  = 0;
    chk_cls = 0;
    repeat (3) @(posedge pxlClk);
    #1;
    rstN = 1'b1;
  endtask

  // One frame: n_lines lines, nact de lines starting at line 2, optional odd
  // line length at bad_idx, vsync rising with line 0's hsync (coinc) or mid-line.
  task automatic send_frame(input int n_lines, input int nact, input int bad_idx,
                            input int bad_len, input bit coinc, input int rst_line);
    int len, last;
    bit fbad, h, v, d;
    fbad = 0;
    last = WT;
    for (int l = 0; l < n_lines; l++) begin
      len = (l == bad_idx) ? bad_len : WT;
      if (l >= 1 && len != WT) fbad = 1;
      if (len >= 2047) fbad = 1;
      if (l == n_lines - 1) last = len;
    end
    for (int l = 0; l < n_lines; l++) begin
      len = (l == bad_idx) ? bad_len : WT;
      for (int c = 0; c < len; c++) begin
        h = (c < HS_W);
        if (coinc)
          v = (l < VS_LINES);
        else
          v = (l > 0 || c >= VS_MID) && (l < VS_LINES || (l == VS_LINES && c < VS_MID));
        d = (l >= 2) && (l < 2 + nact) && (c >= DE_START) && (c < DE_START + AW);
        if (l == rst_line && c == 10) do_reset();
        drive(h, v, d);
      end
      if (l == 0) begin
        prev_lines = n_lines;
        prev_act   = nact;
        prev_last  = last;
        prev_bad   = fbad;
      end
    end
  endtask

  task automatic pick_len(output int bl);
    bl = $urandom_range(21, 40);
    if (bl == WT) bl = WT + 1;
  endtask

  int kind, nl, na, bi, bl;
  bit co;

  initial begin
    repeat (4) @(posedge pxlClk);
    #1;
    check_all_zero("reset");
    rstN = 1'b1;

    // Nominal timing: lock at the 4th classification.
    repeat (6) send_frame(HT, AH, -1, WT, 0, -1);
    check("locked_nominal", locked, 1);

    // One long line while locked, then relock.
    send_frame(HT, AH, 5, WT + 1, 0, -1);
    repeat (5) send_frame(HT, AH, -1, WT, 0, -1);

    // vsync coincident with hsync.
    repeat (3) send_frame(HT, AH, -1, WT, 1, -1);

    // hsync stuck low long enough to saturate the pixel counter.
    send_frame(HT, AH, HT - 1, 3000, 0, -1);
    send_frame(HT, AH, -1, WT, 1, -1);

    // An odd first line is outside the frame's line-length check.
    send_frame(HT, AH, 0, 30, 0, -1);

    // Reset mid-frame, then recover.
    send_frame(HT, AH, -1, WT, 0, 10);
    repeat (6) send_frame(HT, AH, -1, WT, 0, -1);

    // Randomized frames.
    for (int f = 0; f < 24; f++) begin
      kind = $urandom_range(0, 9);
      nl = HT; na = AH; bi = -1; bl = WT;
      co = 1'($urandom_range(0, 1));
      case (kind)
        0: nl = HT + 1;
        1: nl = HT - 1;
        2: na = AH - 1;
        3: begin bi = $urandom_range(1, HT - 1); pick_len(bl); end
        4: begin bi = 0; pick_len(bl); end
        default: ;
      endcase
      send_frame(nl, na, bi, bl, co, -1);
    end
    send_frame(HT, AH, -1, WT, 0, -1);
    repeat (4) tick();

    check("frameStart_pulses", mon_fs, vs_rises);
    check("mismatch_pulses", mon_mis, exp_mis);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
